// File: rtl/threshold_stream_pkg.sv
// Shared definitions for the threshold stream: compare-mode encodings, scan FSM
// states and frame-geometry helpers.
package thr_pkg;

  localparam logic [1:0] MODE_DARK   = 2'd0;
  localparam logic [1:0] MODE_BRIGHT = 2'd1;
  localparam logic [1:0] MODE_BAND   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } thr_state_e;

  function automatic int interior_count(input int w, input int h);
    return (w - 2) * (h - 2);
  endfunction

  function automatic int first_addr(input int w);
    return w + 1;
  endfunction

  function automatic int last_addr(input int w, input int h);
    return (h - 2) * w + (w - 2);
  endfunction

endpackage

// File: rtl/threshold_stream_if.sv
// Control, pixel-RAM read and result-RAM write signals of the threshold stream.
interface threshold_stream_if #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
);
  logic              start;
  logic              src_valid;
  logic [1:0]        mode;
  logic [PIX_W-1:0]  thr_lo;
  logic [PIX_W-1:0]  thr_hi;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [PIX_W-1:0]  rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic              busy;
  logic              done;

  // master: controller plus pixel RAM; slave: the stream block itself
  modport master (
    output start, src_valid, mode, thr_lo, thr_hi, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, src_valid, mode, thr_lo, thr_hi, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/threshold_stream_compare.sv
// Combinational mode/threshold comparator; mode 3 and unknown encodings act as DARK.
module thr_compare
  import thr_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [1:0]       mode_i,
  input  logic [PIX_W-1:0] pix_i,
  input  logic [PIX_W-1:0] lo_i,
  input  logic [PIX_W-1:0] hi_i,
  output logic             res_o
);

  always_comb begin
    res_o = !(pix_i > lo_i);
    case (mode_i)
      MODE_BRIGHT: res_o = (pix_i > lo_i);
      MODE_BAND:   res_o = (pix_i >= lo_i) && (pix_i <= hi_i);
      default:     ;
    endcase
  end

endmodule

// File: rtl/threshold_stream.sv
// Interior-pixel binarizer: one read per cycle over the frame interior, result
// written RD_LAT cycles later alongside the address carried through the delay line.
module threshold_stream
  import thr_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               reset,
  threshold_stream_if.slave bus
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(first_addr(IMG_W));
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 2);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 2);

  thr_state_e        state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic              rd_en, accept, cmp_res, wr_data_q;
  logic [1:0]        mode_q;
  logic [PIX_W-1:0]  lo_q, hi_q;

  // Stage 0 is the read being issued this cycle; stage RD_LAT is the write.
  logic [RD_LAT:1]              vld_pipe_q;
  logic [RD_LAT:0]              vld_pipe;
  logic [RD_LAT:1][ADDR_W-1:0]  addr_pipe_q;
  logic [RD_LAT:0][ADDR_W-1:0]  addr_pipe;

  assign vld_pipe  = {vld_pipe_q, rd_en};
  assign addr_pipe = {addr_pipe_q, addr_q};

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    done_d  = done_q;
    rd_en   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.src_valid) begin
          rd_en = 1'b1;
          if (row_q == ROW_LAST && col_q == COL_LAST) begin
            // park the scan position on the first interior pixel for the next frame
            row_d   = ROW_W'(1);
            col_d   = COL_W'(1);
            addr_d  = ADDR_FIRST;
            state_d = ST_DRAIN;
          end else if (col_q == COL_LAST) begin
            row_d  = row_q + ROW_W'(1);
            col_d  = COL_W'(1);
            addr_d = addr_q + ADDR_W'(3);
          end else begin
            col_d  = col_q + COL_W'(1);
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // leave in the same cycle the final write is presented
        if (!(|vld_pipe[RD_LAT-1:0])) begin
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  thr_compare #(.PIX_W(PIX_W)) u_cmp (
    .mode_i (mode_q),
    .pix_i  (bus.rd_data),
    .lo_i   (lo_q),
    .hi_i   (hi_q),
    .res_o  (cmp_res)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_q       <= ROW_W'(1);
      col_q       <= COL_W'(1);
      addr_q      <= ADDR_FIRST;
      done_q      <= 1'b0;
      vld_pipe_q  <= '0;
      addr_pipe_q <= {RD_LAT{ADDR_FIRST}};
      wr_data_q   <= 1'b1;
      mode_q      <= MODE_DARK;
      lo_q        <= '0;
      hi_q        <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      vld_pipe_q  <= vld_pipe[RD_LAT-1:0];
      addr_pipe_q <= addr_pipe[RD_LAT-1:0];
      if (vld_pipe[RD_LAT-1]) wr_data_q <= cmp_res;
      if (accept) begin
        mode_q <= bus.mode;
        lo_q   <= bus.thr_lo;
        hi_q   <= bus.thr_hi;
      end
    end
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = addr_q;
  assign bus.wr_en   = vld_pipe_q[RD_LAT];
  assign bus.wr_addr = addr_pipe_q[RD_LAT];
  assign bus.wr_data = wr_data_q;
  assign bus.busy    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done    = done_q;

endmodule

// File: tb/tb_threshold_stream.sv
// Three threshold_stream instances (128x128/lat1, 128x4/lat3, 4x4/lat2) driven
// concurrently; expected reads/writes come from a scan-order model and a scoreboard.
module tb_threshold_stream;

  localparam int NI = 3;
  localparam int CW[NI] = '{128, 128, 4};
  localparam int CH[NI] = '{128, 4, 4};
  localparam int CL[NI] = '{1, 3, 2};

  typedef struct {
    int cyc;
    int addr;
    bit d;
  } wr_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic       start_a[NI], sv_a[NI], rst_a[NI];
  logic [1:0] mode_a[NI];
  logic [7:0] lo_a[NI], hi_a[NI];
  logic [7:0] mem[NI][16384];

  int      exp_rd_q[NI][$];
  wr_exp_t wr_q[NI][$];
  bit      in_frame[NI], exp_done[NI];
  int      wr_cnt[NI];
  logic [1:0] fm[NI];
  logic [7:0] flo[NI], fhi[NI];

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0h want %0h cyc %0d", nm, g, act, exp, cyc);
    end
  endtask

  function automatic bit ref_bin(input logic [1:0] md, input logic [7:0] lo, input logic [7:0] hi,
                                 input logic [7:0] p);
    if (md == 2'd2) return (p >= lo) && (p <= hi);
    if (md == 2'd1) return p > lo;
    return p <= lo;
  endfunction

  function automatic logic [7:0] pick(input logic [7:0] lo, input logic [7:0] hi);
    case ($urandom_range(0, 7))
      0: return lo - 8'd1;
      1: return lo;
      2: return lo + 8'd1;
      3: return hi - 8'd1;
      4: return hi;
      5: return hi + 8'd1;
      6: return ($urandom_range(0, 1) != 0) ? 8'd255 : 8'd0;
      default: return 8'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    localparam int W   = CW[g];
    localparam int LAT = CL[g];
    localparam int N   = (CW[g] - 2) * (CH[g] - 2);

    threshold_stream_if #(.PIX_W(8), .ADDR_W(14)) bus();

    threshold_stream #(
      .PIX_W(8), .IMG_W(W), .IMG_H(CH[g]), .ADDR_W(14), .RD_LAT(LAT)
    ) dut (
      .clk   (clk),
      .reset (rst_a[g]),
      .bus   (bus)
    );

    // pixel RAM: data for the address issued RD_LAT-1 cycles ago
    logic [13:0] ap1, ap2, ap3;
    always @(posedge clk) begin
      ap1 <= bus.rd_addr;
      ap2 <= ap1;
      ap3 <= ap2;
    end
    wire [13:0] ram_a = (LAT == 1) ? bus.rd_addr : (LAT == 2) ? ap1 : (LAT == 3) ? ap2 : ap3;

    assign bus.start     = start_a[g];
    assign bus.src_valid = sv_a[g];
    assign bus.mode      = mode_a[g];
    assign bus.thr_lo    = lo_a[g];
    assign bus.thr_hi    = hi_a[g];
    assign bus.rd_data   = mem[g][ram_a];

    always @(negedge clk) begin
      int a;
      wr_exp_t e;
      if (rst_a[g]) begin
        chk("rst_rd_en",   g, 32'(bus.rd_en),   32'd0);
        chk("rst_wr_en",   g, 32'(bus.wr_en),   32'd0);
        chk("rst_wr_data", g, 32'(bus.wr_data), 32'd1);
        chk("rst_busy",    g, 32'(bus.busy),    32'd0);
        chk("rst_done",    g, 32'(bus.done),    32'd0);
        chk("rst_rd_addr", g, 32'(bus.rd_addr), 32'(W + 1));
        chk("rst_wr_addr", g, 32'(bus.wr_addr), 32'(W + 1));
      end else begin
        chk("busy", g, 32'(bus.busy), 32'(in_frame[g]));
        chk("done", g, 32'(bus.done), 32'(exp_done[g]));
        if (exp_rd_q[g].size() > 0) chk("rd_issue", g, 32'(bus.rd_en), 32'(sv_a[g]));
        else                        chk("rd_idle",  g, 32'(bus.rd_en), 32'd0);
        if (bus.rd_en && exp_rd_q[g].size() > 0) begin
          a = exp_rd_q[g].pop_front();
          chk("rd_addr", g, 32'(bus.rd_addr), 32'(a));
          e.cyc  = cyc;
          e.addr = a;
          e.d    = ref_bin(fm[g], flo[g], fhi[g], mem[g][a]);
          wr_q[g].push_back(e);
        end
        if (bus.wr_en) begin
          if (wr_q[g].size() == 0) chk("wr_unexpected", g, 32'(bus.wr_en), 32'd0);
          else begin
            e = wr_q[g].pop_front();
            chk("wr_latency", g, 32'(cyc - e.cyc), 32'(LAT));
            chk("wr_addr",    g, 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data",    g, 32'(bus.wr_data), 32'(e.d));
            wr_cnt[g]++;
            if (wr_cnt[g] == N) begin
              in_frame[g] = 1'b0;
              exp_done[g] = 1'b1;
            end
          end
        end
      end
    end
  end

  // pat: 0 always valid, 1 toggling, 2 random, 3 five-cycle stall mid-row
  task automatic run_frame(input int g, input logic [1:0] md, input logic [7:0] lo,
                           input logic [7:0] hi, input int pat, input int abort_at,
                           input bit busy_start, input bit done_start);
    int w, h, n, k;
    w = CW[g];
    h = CH[g];
    n = (w - 2) * (h - 2);
    for (int a = 0; a < w * h; a++) mem[g][a] = pick(lo, hi);
    @(posedge clk); #1;
    mode_a[g] = md; lo_a[g] = lo; hi_a[g] = hi; start_a[g] = 1'b1;
    @(posedge clk); #1;
    start_a[g] = 1'b0;
    fm[g] = md; flo[g] = lo; fhi[g] = hi;
    for (int r = 1; r <= h - 2; r++)
      for (int c = 1; c <= w - 2; c++) exp_rd_q[g].push_back(r * w + c);
    wr_cnt[g] = 0;
    in_frame[g] = 1'b1;
    exp_done[g] = 1'b0;
    k = 0;
    while (in_frame[g] && k < 4 * n + 100) begin
      case (pat)
        0:       sv_a[g] = 1'b1;
        1:       sv_a[g] = (k % 2 == 0);
        2:       sv_a[g] = ($urandom_range(0, 3) != 0);
        default: sv_a[g] = !(k >= 40 && k < 45);
      endcase
      mode_a[g] = 2'($urandom);
      lo_a[g]   = 8'($urandom);
      hi_a[g]   = 8'($urandom);
      start_a[g] = busy_start && (k == 1);
      if (abort_at > 0 && wr_cnt[g] >= abort_at) begin
        rst_a[g] = 1'b1;
        start_a[g] = 1'b0;
        exp_rd_q[g].delete();
        wr_q[g].delete();
        in_frame[g] = 1'b0;
        exp_done[g] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_a[g] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      k++;
    end
    start_a[g] = 1'b0;
    chk("frame_timeout", g, 32'(in_frame[g]), 32'd0);
    chk("wr_count", g, 32'(wr_cnt[g]), 32'(n));
    // this cycle the block sits in DONE; a start here must be ignored
    if (done_start) start_a[g] = 1'b1;
    @(posedge clk); #1;
    start_a[g] = 1'b0;
    sv_a[g] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int g = 0; g < NI; g++) begin
      rst_a[g] = 1'b1; start_a[g] = 1'b0; sv_a[g] = 1'b1;
      mode_a[g] = 2'd0; lo_a[g] = 8'd0; hi_a[g] = 8'd0;
      in_frame[g] = 1'b0; exp_done[g] = 1'b0; wr_cnt[g] = 0;
      fm[g] = 2'd0; flo[g] = 8'd0; fhi[g] = 8'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < NI; g++) rst_a[g] = 1'b0;
    fork
      begin
        run_frame(0, 2'd0, 8'd1, 8'd0, 0, 0, 1'b0, 1'b0);
        run_frame(0, 2'd0, 8'd1, 8'd0, 0, 100, 1'b0, 1'b0);
        run_frame(0, 2'd1, 8'd2, 8'd0, 0, 0, 1'b0, 1'b1);
      end
      begin
        run_frame(1, 2'd2, 8'd50, 8'd100, 3, 0, 1'b0, 1'b0);
        run_frame(1, 2'd2, 8'd100, 8'd50, 1, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
          run_frame(1, 2'($urandom), 8'($urandom), 8'($urandom), 2, 0, 1'b1, 1'b1);
      end
      begin
        for (int j = 0; j < 8; j++)
          run_frame(2, 2'(j % 4), 8'($urandom), 8'($urandom), j % 3, 0, j[0], 1'b1);
      end
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
